// File: rtl/bp_resolver_pkg.sv
// rtl/bp_resolver_pkg.sv - shared defaults and sizing helpers for the branch resolver
package bp_resolver_pkg;

  localparam int BP_DEPTH = 4;
  localparam int BP_CW    = 16;
  localparam int BP_PTR_W = $clog2(BP_DEPTH);
  localparam logic [BP_CW-1:0] BP_SAT_MAX = {BP_CW{1'b1}};

  // Pointer width for a given depth; depth 1 still needs a 1-bit pointer.
  function automatic int ptr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/bp_pred_fifo.sv
// rtl/bp_pred_fifo.sv - 1-bit DEPTH-entry synchronous FIFO of outstanding predictions
module bp_pred_fifo
  import bp_resolver_pkg::*;
#(
  parameter int DEPTH = BP_DEPTH,
  localparam int PW   = ptr_w(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        push_data,
  input  logic        pop,
  output logic        pop_data,
  output logic [PW:0] count,
  output logic        full,
  output logic        empty
);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/bp_resolver.sv
// rtl/bp_resolver.sv - pairs resolved outcomes with queued predictions, drives predictor update
module bp_resolver
  import bp_resolver_pkg::*;
#(
  parameter int DEPTH = BP_DEPTH,
  parameter int CW    = BP_CW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pred_valid,
  input  logic                   pred_taken,
  input  logic                   res_valid,
  input  logic                   res_taken,
  output logic                   upd_branch,
  output logic                   upd_taken,
  output logic                   mispredict,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [CW-1:0]          hit_count,
  output logic [CW-1:0]          miss_count,
  output logic                   err
);

  localparam logic [CW-1:0] SAT = {CW{1'b1}};

  logic pop_ok;
  logic push_ok;
  logic stored_pred;
  logic miss;

  // No bypass: a resolve against an empty queue is rejected even if a push lands this cycle.
  assign pop_ok  = res_valid && !empty;
  assign push_ok = pred_valid && (!full || pop_ok);
  assign miss    = (stored_pred != res_taken);

  bp_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_ok),
    .push_data (pred_taken),
    .pop       (pop_ok),
    .pop_data  (stored_pred),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      upd_branch <= 1'b0;
      upd_taken  <= 1'b0;
      mispredict <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      err        <= 1'b0;
    end else begin
      upd_branch <= pop_ok;
      upd_taken  <= pop_ok && res_taken;
      mispredict <= pop_ok && miss;
      if (pop_ok && !miss && hit_count != SAT) begin
        hit_count <= hit_count + 1'b1;
      end
      if (pop_ok && miss && miss_count != SAT) begin
        miss_count <= miss_count + 1'b1;
      end
      if ((pred_valid && full && !pop_ok) || (res_valid && empty)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bp_resolver.sv
// tb/tb_bp_resolver.sv - scoreboard bench for bp_resolver
module tb_bp_resolver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pred_valid = 1'b0, pred_taken = 1'b0, res_valid = 1'b0, res_taken = 1'b0;
  logic        upd_branch, upd_taken, mispredict, full, empty, err;
  logic [2:0]  count;
  logic [15:0] hit_count, miss_count;

  logic        b_pred_valid = 1'b0, b_pred_taken = 1'b0, b_res_valid = 1'b0, b_res_taken = 1'b0;
  logic        b_upd_branch, b_upd_taken, b_mispredict, b_full, b_empty, b_err;
  logic [2:0]  b_count;
  logic [2:0]  b_hit_count, b_miss_count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        taken;
    logic        mis;
    logic [15:0] hit;
    logic [15:0] miss;
  } upd_t;
  upd_t exp_q[$];

  always #5 clk = ~clk;

  bp_resolver #(.DEPTH(4), .CW(16)) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_taken(res_taken),
    .upd_branch(upd_branch), .upd_taken(upd_taken), .mispredict(mispredict),
    .full(full), .empty(empty), .count(count),
    .hit_count(hit_count), .miss_count(miss_count), .err(err)
  );

  bp_resolver #(.DEPTH(4), .CW(3)) dut_sat (
    .clk(clk), .reset(reset),
    .pred_valid(b_pred_valid), .pred_taken(b_pred_taken),
    .res_valid(b_res_valid), .res_taken(b_res_taken),
    .upd_branch(b_upd_branch), .upd_taken(b_upd_taken), .mispredict(b_mispredict),
    .full(b_full), .empty(b_empty), .count(b_count),
    .hit_count(b_hit_count), .miss_count(b_miss_count), .err(b_err)
  );

  // Monitor: every update the DUT presents must match the oldest expected entry.
  always @(negedge clk) begin : monitor
    upd_t e;
    if (upd_branch) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_update at %0t: taken=%0b mis=%0b, none required", $time, upd_taken, mispredict);
      end else begin
        e = exp_q.pop_front();
        if (upd_taken !== e.taken || mispredict !== e.mis || hit_count !== e.hit || miss_count !== e.miss) begin
          miscompares++;
          $display("FAIL update at %0t: got taken=%0b mis=%0b hit=%0d miss=%0d, required taken=%0b mis=%0b hit=%0d miss=%0d",
                   $time, upd_taken, mispredict, hit_count, miss_count, e.taken, e.mis, e.hit, e.miss);
        end
      end
    end else if (upd_taken || mispredict) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_outputs at %0t: upd_taken=%0b mispredict=%0b without upd_branch", $time, upd_taken, mispredict);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic expect_upd(input logic t, input logic m, input int h, input int ms);
    upd_t e;
    e.taken = t; e.mis = m; e.hit = 16'(h); e.miss = 16'(ms);
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic pv, input logic pt, input logic rv, input logic rt);
    pred_valid = pv; pred_taken = pt; res_valid = rv; res_taken = rt;
    @(posedge clk); #1;
    pred_valid = 1'b0; res_valid = 1'b0;
  endtask

  task automatic cyc_b(input logic pv, input logic pt, input logic rv, input logic rt);
    b_pred_valid = pv; b_pred_taken = pt; b_res_valid = rv; b_res_taken = rt;
    @(posedge clk); #1;
    b_pred_valid = 1'b0; b_res_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int exp_sat[9] = '{1, 2, 3, 4, 5, 6, 7, 7, 7};
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk("reset_count", 32'(count), 0);
    chk("reset_empty", 32'(empty), 1);
    chk("reset_full", 32'(full), 0);
    chk("reset_err", 32'(err), 0);
    chk("reset_hit", 32'(hit_count), 0);
    chk("reset_upd", 32'(upd_branch), 0);

    // Basic hit
    cyc(1, 1, 0, 0);
    expect_upd(1, 0, 1, 0);
    cyc(0, 0, 1, 1);
    @(negedge clk);
    chk("basic_empty", 32'(empty), 1);

    // FIFO order: predictions 1,0,0,1 against outcomes 1,1,0,0
    cyc(1, 1, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 1, 0, 0);
    @(negedge clk);
    chk("order_full", 32'(full), 1);
    chk("order_count", 32'(count), 4);
    expect_upd(1, 0, 2, 0); cyc(0, 0, 1, 1);
    expect_upd(1, 1, 2, 1); cyc(0, 0, 1, 1);
    expect_upd(0, 0, 3, 1); cyc(0, 0, 1, 0);
    expect_upd(0, 1, 3, 2); cyc(0, 0, 1, 0);
    @(negedge clk);
    chk("order_empty", 32'(empty), 1);
    chk("order_miss", 32'(miss_count), 2);

    // Full with simultaneous push/pop, then push while full
    cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
    expect_upd(1, 0, 4, 2);
    cyc(1, 0, 1, 1);
    @(negedge clk);
    chk("fullpp_count", 32'(count), 4);
    chk("fullpp_err", 32'(err), 0);
    cyc(1, 1, 0, 0);
    @(negedge clk);
    chk("fullpush_err", 32'(err), 1);
    chk("fullpush_count", 32'(count), 4);
    expect_upd(1, 0, 5, 2); cyc(0, 0, 1, 1);
    expect_upd(1, 0, 6, 2); cyc(0, 0, 1, 1);
    expect_upd(1, 0, 7, 2); cyc(0, 0, 1, 1);
    expect_upd(1, 1, 7, 3); cyc(0, 0, 1, 1);
    @(negedge clk);
    chk("fullpp_empty", 32'(empty), 1);

    // Empty resolve, alone and with a simultaneous push
    do_reset();
    cyc(0, 0, 1, 1);
    @(negedge clk);
    chk("emptyres_err", 32'(err), 1);
    chk("emptyres_hit", 32'(hit_count), 0);
    chk("emptyres_miss", 32'(miss_count), 0);
    cyc(1, 1, 1, 1);
    @(negedge clk);
    chk("emptyres_push_count", 32'(count), 1);
    expect_upd(1, 0, 1, 0);
    cyc(0, 0, 1, 1);
    @(negedge clk);
    chk("emptyres_drain", 32'(empty), 1);

    // Reset mid-operation
    do_reset();
    cyc(1, 1, 0, 0); expect_upd(1, 0, 1, 0); cyc(0, 0, 1, 1);
    cyc(1, 1, 0, 0); expect_upd(1, 0, 2, 0); cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 0);
    cyc(1, 1, 0, 0); cyc(1, 0, 0, 0); cyc(1, 1, 0, 0);
    @(negedge clk);
    chk("pre_reset_count", 32'(count), 3);
    chk("pre_reset_hit", 32'(hit_count), 2);
    chk("pre_reset_err", 32'(err), 1);
    reset = 1'b1; pred_valid = 1'b1; pred_taken = 1'b1; res_valid = 1'b1; res_taken = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; pred_valid = 1'b0; res_valid = 1'b0;
    @(negedge clk);
    chk("midreset_count", 32'(count), 0);
    chk("midreset_empty", 32'(empty), 1);
    chk("midreset_hit", 32'(hit_count), 0);
    chk("midreset_err", 32'(err), 0);
    chk("midreset_upd", 32'(upd_branch), 0);
    cyc(1, 1, 0, 0);
    expect_upd(1, 0, 1, 0);
    cyc(0, 0, 1, 1);
    @(negedge clk);
    chk("postreset_empty", 32'(empty), 1);

    // Saturation on the CW=3 instance
    for (int i = 0; i < 9; i++) begin
      cyc_b(1, 1, 0, 0);
      cyc_b(0, 0, 1, 1);
      @(negedge clk);
      chk($sformatf("sat_hit_%0d", i + 1), 32'(b_hit_count), 32'(exp_sat[i]));
    end
    chk("sat_miss", 32'(b_miss_count), 0);
    chk("sat_err", 32'(b_err), 0);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
